// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding,
// line-control-register field positions, word-length decode and the bit
// positions of the per-character error flags stored alongside each byte.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // lcr fields; bits [2] and [7:6] carry nothing for the receiver
  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_STICK  = 5;

  // error flag positions inside the 3-bit error tag
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;
  localparam int ERR_W   = 3;

  // word length select 0..3 -> 5..8 data bits
  function automatic logic [3:0] word_len(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Synchronous first-word-fall-through FIFO for received characters.
// The head entry is always visible on rd_data while the FIFO is non-empty and
// reads as zero when empty.
//   clk, rst    : clock, synchronous active-low reset
//   wr_en/data  : push; dropped when full unless a pop happens in the same cycle
//   rd_en       : pop head; ignored when empty
//   rd_data     : head entry
//   full, empty : status
//   count       : occupancy 0..DEPTH
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  import uart_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Oversampling UART receiver feeding an error-tagged FWFT receive FIFO.
//   clk, rst          : clock, synchronous active-low reset
//   ideal_rx          : holds the receiver idle, aborting any frame in flight
//   rx                : asynchronous serial input, idle high
//   lcr               : [1:0] word length, [3] parity en, [4] even, [5] stick
//   dll, dlh          : baud divisor {dlh,dll}; 0 stops the oversample tick
//   rd_en             : pop FIFO head
//   rx_trig           : interrupt trigger level (0 behaves as 1)
//   rd_data, rd_err   : head character and {break, framing, parity} flags
//   rx_empty, rx_full : FIFO status
//   rx_count          : FIFO occupancy
//   overrun           : sticky, set when a character is dropped on a full FIFO
//   irq               : trigger level | head has errors | idle timeout
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a 1->0 transition on rx_s
// ST_START  | validating the start bit at its centre
// ST_DATA   | sampling data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit; result pushed the following cycle
module uart_rx_core #(
  parameter int OVS      = 16,
  parameter int DEPTH    = 16,
  parameter int TO_CHARS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ideal_rx,
  input  logic                         rx,
  input  logic [7:0]                   lcr,
  input  logic [7:0]                   dll,
  input  logic [7:0]                   dlh,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH+1)-1:0]   rx_trig,
  output logic [7:0]                   rd_data,
  output logic [2:0]                   rd_err,
  output logic                         rx_empty,
  output logic                         rx_full,
  output logic [$clog2(DEPTH+1)-1:0]   rx_count,
  output logic                         overrun,
  output logic                         irq
);
  import uart_pkg::*;

  localparam int SW       = $clog2(OVS + 3);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int TO_TICKS = TO_CHARS * 10 * OVS;
  localparam int TW       = $clog2(TO_TICKS + 1);

  // ---------------- synchroniser and edge detect ----------------
  logic rx_m, rx_s, rx_s_d;
  logic fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d && !rx_s;

  // ---------------- oversample tick ----------------
  // The divisor in use is only refreshed at a wrap, so a new divisor never
  // truncates or stretches the period already in progress.
  logic [15:0] divisor, div_cur, div_cnt;
  logic        tick;

  assign divisor = {dlh, dll};
  assign tick    = (div_cur != '0) && (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cur <= '0;
      div_cnt <= '0;
    end else if (div_cur == '0 || div_cnt == '0) begin
      div_cur <= divisor;
      div_cnt <= divisor - 16'd1;
    end else begin
      div_cnt <= div_cnt - 16'd1;
    end
  end

  // ---------------- receiver FSM ----------------
  rx_state_e state, state_nx;

  logic [SW-1:0] samp_cnt, samp_n;
  logic [2:0]    bit_idx;
  logic          s0, s1, maj;
  logic [7:0]    data_sh;
  logic          par_q;
  logic [1:0]    wls_q;
  logic          pen_q, eps_q, stick_q;
  logic          start_dec, bit_dec, last_bit;

  logic cnt_clr, cnt_inc, cnt_reload, latch_lcr;
  logic take_s0, take_s1, cap_data, cap_par, cap_stop;

  // samp_cnt counts ticks since the previous bit centre; the three votes sit
  // at OVS, OVS+1, OVS+2 ticks after it and the decision is made on the last.
  assign samp_n    = samp_cnt + 1'b1;
  assign start_dec = tick && (samp_n == SW'(OVS / 2));
  assign bit_dec   = tick && (samp_n == SW'(OVS + 2));
  assign last_bit  = ({1'b0, bit_idx} == (word_len(wls_q) - 4'd1));
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ideal_rx) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (fall) state_nx = ST_START;
        ST_START:  if (start_dec) state_nx = rx_s ? ST_IDLE : ST_DATA;
        ST_DATA:   if (bit_dec && last_bit) state_nx = pen_q ? ST_PARITY : ST_STOP;
        ST_PARITY: if (bit_dec) state_nx = ST_STOP;
        ST_STOP:   if (bit_dec) state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_reload = 1'b0;
    latch_lcr  = 1'b0;
    take_s0    = 1'b0;
    take_s1    = 1'b0;
    cap_data   = 1'b0;
    cap_par    = 1'b0;
    cap_stop   = 1'b0;
    if (ideal_rx) begin
      cnt_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: cnt_clr = 1'b1;
        ST_START: begin
          cnt_inc = tick;
          if (start_dec && !rx_s) begin
            latch_lcr = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        ST_DATA, ST_PARITY, ST_STOP: begin
          cnt_inc = tick;
          take_s0 = tick && (samp_n == SW'(OVS));
          take_s1 = tick && (samp_n == SW'(OVS + 1));
          if (bit_dec) begin
            cnt_reload = 1'b1;
            cap_data   = (state == ST_DATA);
            cap_par    = (state == ST_PARITY);
            cap_stop   = (state == ST_STOP);
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  // ---------------- frame datapath ----------------
  logic       par_err, brk;
  logic       push_q;
  logic [7:0] push_data;
  logic [2:0] push_err;

  // data_sh is cleared at frame start, so bits above the word length stay 0
  // and take no part in the parity sum or the break test.
  always_comb begin
    par_err = 1'b0;
    if (pen_q) begin
      if (stick_q) par_err = (par_q == eps_q);
      else         par_err = ((^data_sh) ^ par_q) == eps_q;
    end
  end

  assign brk = (data_sh == '0) && (!pen_q || !par_q) && !maj;

  always_ff @(posedge clk) begin
    if (!rst) begin
      samp_cnt  <= '0;
      bit_idx   <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      data_sh   <= '0;
      par_q     <= 1'b0;
      wls_q     <= '0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      stick_q   <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      push_err  <= '0;
    end else begin
      push_q <= 1'b0;

      if (cnt_clr)         samp_cnt <= '0;
      else if (cnt_reload) samp_cnt <= SW'(2);
      else if (cnt_inc)    samp_cnt <= samp_n;

      if (latch_lcr) begin
        wls_q   <= lcr[LCR_WLS_HI:LCR_WLS_LO];
        pen_q   <= lcr[LCR_PEN];
        eps_q   <= lcr[LCR_EPS];
        stick_q <= lcr[LCR_STICK];
        data_sh <= '0;
        bit_idx <= '0;
      end

      if (take_s0) s0 <= rx_s;
      if (take_s1) s1 <= rx_s;

      if (cap_data) begin
        data_sh[bit_idx] <= maj;
        bit_idx          <= bit_idx + 1'b1;
      end

      if (cap_par) par_q <= maj;

      if (cap_stop) begin
        push_q            <= 1'b1;
        push_data         <= data_sh;
        push_err[ERR_PAR] <= par_err;
        push_err[ERR_FRM] <= !maj;
        push_err[ERR_BRK] <= brk;
      end
    end
  end

  logic [7:0] lcr_unused;
  assign lcr_unused = {lcr[7:6], lcr[2], 5'b0};

  // ---------------- receive FIFO ----------------
  logic [ERR_W+7:0] head;

  uart_rx_fifo #(
    .WIDTH (ERR_W + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data ({push_err, push_data}),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  assign rd_data = head[7:0];
  assign rd_err  = head[ERR_W+7:8];

  logic push_ok, pop_ok;
  assign push_ok = push_q && (!rx_full || rd_en);
  assign pop_ok  = rd_en && !rx_empty;

  always_ff @(posedge clk) begin
    if (!rst)                           overrun <= 1'b0;
    else if (push_q && rx_full && !rd_en) overrun <= 1'b1;
    else if (pop_ok)                    overrun <= 1'b0;
  end

  // ---------------- idle timeout ----------------
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt  <= TW'(TO_TICKS);
      to_flag <= 1'b0;
    end else if (push_ok || pop_ok || rx_empty) begin
      to_cnt  <= TW'(TO_TICKS);
      to_flag <= 1'b0;
    end else if (tick && !to_flag) begin
      if (to_cnt == TW'(1)) to_flag <= 1'b1;
      to_cnt <= to_cnt - 1'b1;
    end
  end

  // ---------------- interrupt ----------------
  logic [CW-1:0] trig_eff;
  assign trig_eff = (rx_trig == '0) ? CW'(1) : rx_trig;
  assign irq = (rx_count >= trig_eff) || (!rx_empty && (rd_err != '0)) || to_flag;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
  localparam int OVS      = 16;
  localparam int DEPTH    = 4;
  localparam int TO_CHARS = 4;
  localparam int BIT      = 32;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, ideal_rx, rx, rd_en;
  logic [7:0]    lcr, dll, dlh;
  logic [CW-1:0] rx_trig;
  logic [7:0]    rd_data;
  logic [2:0]    rd_err;
  logic          rx_empty, rx_full, overrun, irq;
  logic [CW-1:0] rx_count;

  uart_rx_core #(.OVS(OVS), .DEPTH(DEPTH), .TO_CHARS(TO_CHARS)) dut (
    .clk(clk), .rst(rst), .ideal_rx(ideal_rx), .rx(rx), .lcr(lcr),
    .dll(dll), .dlh(dlh), .rd_en(rd_en), .rx_trig(rx_trig),
    .rd_data(rd_data), .rd_err(rd_err), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_count(rx_count), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic pre_stop_empty;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO entry {break, framing, parity, data} from the frame contents
  function automatic logic [10:0] model(input logic [7:0] d, input logic [7:0] l,
                                        input logic par, input logic stop);
    int wl, ones;
    logic [7:0] dm;
    logic perr, brk;
    wl   = 5 + int'(l[1:0]);
    dm   = d & 8'((1 << wl) - 1);
    ones = $countones(dm);
    perr = 1'b0;
    if (l[3]) begin
      if (l[5]) perr = (par != !l[4]);
      else      perr = (((ones + int'(par)) % 2) != (l[4] ? 0 : 1));
    end
    brk = (dm == 8'd0) && (!l[3] || !par) && !stop;
    return {brk, !stop, perr, dm};
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] l,
                            input logic par, input logic stop);
    int wl;
    wl  = 5 + int'(l[1:0]);
    lcr = l;
    drive_bit(1'b0);
    for (int i = 0; i < wl; i++) drive_bit(d[i]);
    if (l[3]) drive_bit(par);
    pre_stop_empty = rx_empty;
    drive_bit(stop);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [10:0] e;
    e = exp_q.pop_front();
    chk({tag, "_data"}, rd_data, e[7:0]);
    chk({tag, "_err"}, rd_err, e[10:8]);
    pop();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, l, d2;
    logic [7:0] ov_d [5];
    logic par, stop;
    int waited;

    rst = 1'b0; ideal_rx = 1'b0; rx = 1'b1; rd_en = 1'b0;
    lcr = 8'h03; dll = 8'd2; dlh = 8'd0; rx_trig = CW'(4);
    repeat (5) @(negedge clk);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_empty", rx_empty, 1);
    chk("rst_full", rx_full, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // basic 8N1
    send_frame(8'hA5, 8'h03, 1'b0, 1'b1);
    chk("a5_pre_stop_empty", pre_stop_empty, 1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_err", rd_err, 0);
    chk("a5_empty", rx_empty, 0);
    chk("a5_count", rx_count, 1);
    pop();
    chk("a5_pop_empty", rx_empty, 1);

    // parity
    send_frame(8'h07, 8'h1B, 1'b0, 1'b1);
    chk("par_data", rd_data, 8'h07);
    chk("par_err", rd_err, 3'b001);
    chk("par_irq", irq, 1);
    pop();
    chk("par_irq_pop", irq, 0);
    send_frame(8'h07, 8'h2B, 1'b1, 1'b1);
    chk("stick_data", rd_data, 8'h07);
    chk("stick_err", rd_err, 0);
    pop();

    // break
    lcr = 8'h03;
    rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("brk_count", rx_count, 1);
    chk("brk_data", rd_data, 0);
    chk("brk_err", rd_err, 3'b110);
    repeat (3 * BIT) @(negedge clk);
    chk("brk_count_hold", rx_count, 1);
    pop();
    chk("brk_empty", rx_empty, 1);

    // overrun with DEPTH=4
    for (int i = 0; i < 5; i++) begin
      ov_d[i] = 8'($urandom);
      send_frame(ov_d[i], 8'h03, 1'b0, 1'b1);
    end
    chk("ov_count", rx_count, 4);
    chk("ov_full", rx_full, 1);
    chk("ov_overrun", overrun, 1);
    chk("ov_irq", irq, 1);
    chk("ov_data0", rd_data, ov_d[0]);
    pop();
    chk("ov_overrun_clr", overrun, 0);
    for (int i = 1; i < 4; i++) begin
      chk("ov_data", rd_data, ov_d[i]);
      pop();
    end
    chk("ov_empty", rx_empty, 1);

    // glitch -> false start
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("glitch_count", rx_count, 0);
    send_frame(8'h3C, 8'h03, 1'b0, 1'b1);
    chk("glitch_next_data", rd_data, 8'h3C);
    pop();

    // ideal_rx aborts a frame
    d = 8'($urandom);
    lcr = 8'h03;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    ideal_rx = 1'b1;
    for (int i = 3; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    repeat (8) @(negedge clk);
    ideal_rx = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk("ideal_count", rx_count, 0);
    d = 8'($urandom);
    exp_q.push_back(model(d, 8'h03, 1'b0, 1'b1));
    send_frame(d, 8'h03, 1'b0, 1'b1);
    pop_check("ideal_next");

    // 5N1, trigger level 2, timeout
    rx_trig = CW'(2);
    send_frame(8'h15, 8'h00, 1'b0, 1'b1);
    chk("t5_data", rd_data, 8'h15);
    chk("t5_irq_lo", irq, 0);
    d2 = 8'($urandom);
    send_frame(d2, 8'h00, 1'b0, 1'b1);
    chk("t5_irq_hi", irq, 1);
    pop();
    chk("t5_data2", rd_data, d2 & 8'h1F);
    pop();
    chk("t5_empty", rx_empty, 1);
    send_frame(8'($urandom), 8'h00, 1'b0, 1'b1);
    repeat (1200) @(negedge clk);
    chk("to_early", irq, 0);
    waited = 0;
    while (!irq && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("to_fire", irq, 1);
    pop();
    rx_trig = CW'(4);

    // randomized frames against the reference model
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 2; j++) begin
        l    = 8'($urandom);
        d    = 8'($urandom);
        par  = 1'($urandom);
        stop = ($urandom_range(0, 7) != 0);
        exp_q.push_back(model(d, l, par, stop));
        send_frame(d, l, par, stop);
      end
      chk("rnd_count", rx_count, 2);
      pop_check("rnd0");
      pop_check("rnd1");
    end
    chk("rnd_empty", rx_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
